// File: rtl/i8bit_mul.sv
// Unsigned 8x8 -> 16 registered multiplier built from Vedic (Urdhva Tiryagbhyam) cells.
// Optional I8BIT_MUL_INREG_EN registers a, b, in_valid ahead of the multiplier (latency 2).
module i8bit_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] s,
  output logic        out_valid
);

  // Handshake: in_valid qualifies a/b for one edge each cycle; out_valid pulses with each
  // fresh product. No backpressure: one result per accepted pair, in order.

  // 2x2 cell: four ANDs and two half adders.
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic p0, t1, t2, t3, s1, c1, s2, c2;
    p0 = x[0] & y[0];
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    s1 = t1 ^ t2;
    c1 = t1 & t2;
    s2 = t3 ^ c1;
    c2 = t3 & c1;
    return {c2, s2, s1, p0};
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, hl, lh, hh;
    logic [5:0] mid;
    logic [3:0] up;
    ll  = mul2(x[1:0], y[1:0]);
    hl  = mul2(x[3:2], y[1:0]);
    lh  = mul2(x[1:0], y[3:2]);
    hh  = mul2(x[3:2], y[3:2]);
    mid = {2'b00, hl} + {2'b00, lh} + {4'b0000, ll[3:2]};
    up  = hh + mid[5:2];
    return {up, mid[1:0], ll[1:0]};
  endfunction

  // Carry out of the upper add is provably zero, so the 8-bit sum is exact.
  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, hl, lh, hh;
    logic [9:0] mid;
    logic [7:0] up;
    ll  = mul4(x[3:0], y[3:0]);
    hl  = mul4(x[7:4], y[3:0]);
    lh  = mul4(x[3:0], y[7:4]);
    hh  = mul4(x[7:4], y[7:4]);
    mid = {2'b00, hl} + {2'b00, lh} + {6'b000000, ll[7:4]};
    up  = hh + {2'b00, mid[9:4]};
    return {up, mid[3:0], ll[3:0]};
  endfunction

  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_v;
  logic [15:0] prod;

`ifdef I8BIT_MUL_INREG_EN
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
      v_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
      v_q <= in_valid;
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign mul_v = v_q;
`else
  assign mul_a = a;
  assign mul_b = b;
  assign mul_v = in_valid;
`endif

  always_comb begin
    prod = mul8(mul_a, mul_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= mul_v;
      if (mul_v) s <= prod;
    end
  end

endmodule

// File: tb/tb_i8bit_mul.sv
// Directed bench for i8bit_mul; latency follows I8BIT_MUL_INREG_EN.
module tb_i8bit_mul;

`ifdef I8BIT_MUL_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] s;
  logic        out_valid;

  int vectors;
  int miscompares;

  i8bit_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    #3;
    vectors++;
    if (s !== 16'h0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: s=%h out_valid=%b expected s=0000 out_valid=0", s, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pairs driven on consecutive cycles; output must track with out_valid held high.
  task automatic test_back_to_back();
    logic [7:0]  va [8];
    logic [7:0]  vb [8];
    logic [15:0] ve [8];
    va = '{8'd12, 8'd240, 8'd170, 8'd255, 8'd171, 8'd238, 8'd0,  8'd1};
    vb = '{8'd5,  8'd15,  8'd85,  8'd255, 8'd205, 8'd255, 8'd255, 8'd201};
    ve = '{16'd60, 16'd3600, 16'd14450, 16'd65025, 16'h88EF, 16'hED12, 16'd0, 16'd201};
    for (int k = 0; k < 8 + LAT - 1; k++) begin
      if (k < 8) drive(1'b1, va[k], vb[k]);
      else       drive(1'b0, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        vectors++;
        if (s !== ve[k-LAT+1] || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b[%0d]: s=%0d out_valid=%b expected s=%0d out_valid=1",
                   k - LAT + 1, s, out_valid, ve[k-LAT+1]);
        end
      end
    end
    drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_commutative();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [15:0] ve [4];
    va = '{8'd31, 8'd15, 8'd0,  8'd77};
    vb = '{8'd15, 8'd31, 8'd77, 8'd0};
    ve = '{16'h01D1, 16'h01D1, 16'd0, 16'd0};
    for (int k = 0; k < 4 + LAT - 1; k++) begin
      if (k < 4) drive(1'b1, va[k], vb[k]);
      else       drive(1'b0, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        vectors++;
        if (s !== ve[k-LAT+1] || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL commute[%0d]: s=%0d out_valid=%b expected s=%0d out_valid=1",
                   k - LAT + 1, s, out_valid, ve[k-LAT+1]);
        end
      end
    end
    drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_hold();
    for (int k = 0; k < LAT + 3; k++) begin
      if (k == 0) drive(1'b1, 8'd12, 8'd5);
      else        drive(1'b0, 8'hFF, 8'hFF);
      @(posedge clk);
      #1;
      if (k == LAT - 1) begin
        vectors++;
        if (s !== 16'd60 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL hold_load: s=%0d out_valid=%b expected s=60 out_valid=1", s, out_valid);
        end
      end else if (k >= LAT) begin
        vectors++;
        if (s !== 16'd60 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL hold[%0d]: s=%0d out_valid=%b expected s=60 out_valid=0", k, s, out_valid);
        end
      end
    end
  endtask

  // Reset between edges with a product in flight, then a clean capture afterwards.
  task automatic test_midop_reset();
    drive(1'b1, 8'd200, 8'd200);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (s !== 16'h0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: s=%h out_valid=%b expected s=0000 out_valid=0", s, out_valid);
    end
    drive(1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (s !== 16'h0000 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: s=%h out_valid=%b expected s=0000 out_valid=0",
                 k, s, out_valid);
      end
    end
    for (int k = 0; k < LAT + 1; k++) begin
      if (k == 0) drive(1'b1, 8'd7, 8'd9);
      else        drive(1'b0, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      if (k == LAT - 1) begin
        vectors++;
        if (s !== 16'd63 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL post_reset_capture: s=%0d out_valid=%b expected s=63 out_valid=1",
                   s, out_valid);
        end
      end
    end
  endtask

  // Streaming sweep: a walks 0..255, b from a fixed scramble of a.
  task automatic test_sweep();
    logic [15:0] exp_q [$];
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] exp;
    for (int k = 0; k < 256 + LAT - 1; k++) begin
      if (k < 256) begin
        av = 8'(k);
        bv = 8'((k * 37 + 11) % 256);
        exp_q.push_back(16'(av) * 16'(bv));
        drive(1'b1, av, bv);
      end else begin
        drive(1'b0, 8'h00, 8'h00);
      end
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        exp = exp_q.pop_front();
        vectors++;
        if (s !== exp || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL sweep[%0d]: s=%0d out_valid=%b expected s=%0d out_valid=1",
                   k - LAT + 1, s, out_valid, exp);
        end
      end
    end
    drive(1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_commutative();
    test_hold();
    test_midop_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
